// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch front end with a small decoupling
// queue between the instruction memory and decode.
// Optional feature: define FETCH_QUEUE_BYPASS_EN so that a response arriving
// at an empty queue is presented to decode in the same cycle.
// rst is synchronous and active low.
module fetch_queue #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_inst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         occ;    // entries held in the queue
  logic [CW-1:0]         outst;  // requests accepted, response not yet seen
  logic [CW-1:0]         drop;   // outstanding responses belonging to a flushed stream
  logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc;
  logic                  init_done;

  logic [CW:0] budget;
  logic        req_fire, resp_drop, resp_keep, bypass, push, pop;
  entry_t      head;

  // Request gating, response classification and output selection.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    budget    = {1'b0, occ} + {1'b0, outst} - {1'b0, drop};
    head      = mem[rd_ptr];
    resp_drop = (drop != '0);
    resp_keep = rst && imem_resp_valid && !resp_drop && !redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass    = resp_keep && (occ == '0);
`else
    bypass    = 1'b0;
`endif
    imem_req_valid = rst && init_done && !redirect_valid && (budget < DEPTH_W);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;

    out_valid = rst && ((occ != '0) || bypass);
    out_pc    = bypass ? resp_pc : head.pc;
    out_inst  = bypass ? imem_resp_inst : head.inst;

    // A bypassed response that decode takes right away never enters the queue.
    push = resp_keep && !(bypass && out_ready);
    pop  = rst && (occ != '0) && out_ready;
  end

  // Control state: PCs, pointers and the occupancy/outstanding/drop counters.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      occ       <= '0;
      outst     <= '0;
      drop      <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (redirect_valid) begin
        // A response in this cycle is discarded; everything still in flight is stale.
        occ      <= '0;
        outst    <= outst - CW'(imem_resp_valid);
        drop     <= outst - CW'(imem_resp_valid);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        occ   <= occ + CW'(push) - CW'(pop);
        outst <= outst + CW'(req_fire) - CW'(imem_resp_valid);
        drop  <= drop - CW'(imem_resp_valid && resp_drop);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
        if (resp_keep) resp_pc  <= resp_pc + PC_STEP;
      end
    end
  end

  // Queue storage write port.
  // NOTE: the storage array has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: resp_pc, inst: imem_resp_inst};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with a small in-order
// instruction memory whose latency is set per test.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  fetch_queue #(.ADDR_WIDTH(64), .INST_WIDTH(32), .DEPTH(4), .RESET_PC(64'h1000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  req_t        pending[$];
  logic [63:0] req_log[$];
  logic [63:0] pc_log[$];
  logic [31:0] inst_log[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {16'hDEAD, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pc_at(input int i);
    return (i < pc_log.size()) ? pc_log[i] : '1;
  endfunction

  function automatic logic [63:0] inst_at(input int i);
    return (i < inst_log.size()) ? 64'(inst_log[i]) : '1;
  endfunction

  function automatic logic [63:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : '1;
  endfunction

  // One clock: log this cycle's handshakes, cross the edge, present the memory response.
  task automatic tick();
    logic rst_s;
    rst_s = rst;
    if (rst_s && imem_req_valid && imem_req_ready) begin
      pending.push_back('{addr: imem_req_addr, due: cyc + lat});
      req_log.push_back(imem_req_addr);
    end
    if (imem_resp_valid && pending.size() > 0) pending.delete(0);
    if (out_valid && out_ready) begin
      pc_log.push_back(out_pc);
      inst_log.push_back(out_inst);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_s) pending.delete();
    if (rst && pending.size() > 0 && pending[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_inst  = inst_of(pending[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_inst  = '0;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pc_log.delete();
    inst_log.delete();
  endtask

  // Single-cycle redirect; the request side must stay quiet in that cycle.
  task automatic redirect_to(input logic [63:0] pc, input string tag);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    check(tag, imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_inst = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    // Reset state.
    ticks(3);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_addr", imem_req_addr, 64'h1000);

    // Streaming from RESET_PC, latency 1, decode always ready.
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1; rst = 1'b1;
    clear_logs();
    #1;
    check("rel_req_valid", imem_req_valid, 1'b0);
    ticks(12);
    imem_req_ready = 1'b0;
    ticks(4);
    check("stream_nreq_ge6", 64'(req_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stream_req%0d", i), req_at(i), 64'h1000 + 64'(4 * i));
      check($sformatf("stream_pc%0d", i), pc_at(i), 64'h1000 + 64'(4 * i));
      check($sformatf("stream_inst%0d", i), inst_at(i), 64'(32'hDEAD_1000 + 32'(4 * i)));
    end
    check("stream_all_out", 64'(pc_log.size()), 64'(req_log.size()));
    check("stream_idle", out_valid, 1'b0);

    // Empty queue, single response: same-cycle with bypass, next cycle without.
    redirect_to(64'h3000, "byp_redir_noreq");
    clear_logs();
    imem_req_ready = 1'b1;
    #1;
    check("byp_req_valid", imem_req_valid, 1'b1);
    check("byp_req_addr", imem_req_addr, 64'h3000);
    tick();
    imem_req_ready = 1'b0;
    #1;
    check("byp_resp_here", imem_resp_valid, 1'b1);
    check("byp_same_cycle", out_valid, BYP);
    tick();
    check("byp_next_cycle", out_valid, !BYP);
    ticks(2);
    check("byp_pc", pc_at(0), 64'h3000);
    check("byp_inst", inst_at(0), 64'hDEAD_3000);
    check("byp_count", 64'(pc_log.size()), 64'd1);

    // Decode stalled: exactly DEPTH requests, then the request side stops.
    redirect_to(64'h4000, "full_redir_noreq");
    clear_logs();
    out_ready = 1'b0; imem_req_ready = 1'b1;
    ticks(10);
    check("full_nreq", 64'(req_log.size()), 64'd4);
    check("full_req_valid", imem_req_valid, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    check("full_hold_pc", out_pc, 64'h4000);
    check("full_hold_inst", 64'(out_inst), 64'hDEAD_4000);
    imem_req_ready = 1'b0; out_ready = 1'b1;
    ticks(6);
    check("full_nout", 64'(pc_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_pc%0d", i), pc_at(i), 64'h4000 + 64'(4 * i));
      check($sformatf("full_inst%0d", i), inst_at(i), 64'(32'hDEAD_4000 + 32'(4 * i)));
    end

    // Three requests in flight at latency 3, then redirect: stale responses dropped.
    lat = 3;
    redirect_to(64'h5000, "stale_redir0_noreq");
    clear_logs();
    imem_req_ready = 1'b1;
    ticks(3);
    check("stale_nreq", 64'(req_log.size()), 64'd3);
    redirect_to(64'h2000, "stale_redir_noreq");
    check("stale_first_addr", imem_req_addr, 64'h2000);
    ticks(6);
    imem_req_ready = 1'b0;
    ticks(8);
    check("stale_first_pc", pc_at(0), 64'h2000);
    check("stale_first_inst", inst_at(0), 64'hDEAD_2000);
    check("stale_second_pc", pc_at(1), 64'h2004);
    check("stale_drained", out_valid, 1'b0);

    // Redirect coinciding with a response and an output handshake.
    lat = 1;
    redirect_to(64'h6000, "coll_redir0_noreq");
    clear_logs();
    out_ready = 1'b0; imem_req_ready = 1'b1;
    ticks(2);
    imem_req_ready = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'h7000;
    #1;
    check("coll_resp_here", imem_resp_valid, 1'b1);
    check("coll_head_pc", out_pc, 64'h6000);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("coll_empty_after", out_valid, 1'b0);
    check("coll_delivered_n", 64'(pc_log.size()), 64'd1);
    check("coll_delivered_pc", pc_at(0), 64'h6000);

    // Back-to-back redirects: the last target wins.
    redirect_valid = 1'b1; redirect_pc = 64'h8000;
    tick();
    redirect_pc = 64'h9000;
    #1;
    check("b2b_noreq", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    clear_logs();
    #1;
    check("b2b_addr", imem_req_addr, 64'h9000);
    ticks(4);
    imem_req_ready = 1'b0;
    ticks(4);
    check("b2b_first_pc", pc_at(0), 64'h9000);
    check("b2b_first_inst", inst_at(0), 64'hDEAD_9000);

    // Reset with the queue half full.
    redirect_to(64'hA000, "mid_redir_noreq");
    out_ready = 1'b0; imem_req_ready = 1'b1;
    ticks(2);
    imem_req_ready = 1'b0;
    ticks(2);
    check("mid_out_valid", out_valid, 1'b1);
    check("mid_head_pc", out_pc, 64'hA000);
    rst = 1'b0;
    tick();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_req_valid", imem_req_valid, 1'b0);
    check("mid_rst_addr", imem_req_addr, 64'h1000);
    rst = 1'b1; imem_req_ready = 1'b1;
    tick();
    check("mid_restart_valid", imem_req_valid, 1'b1);
    check("mid_restart_addr", imem_req_addr, 64'h1000);
    check("mid_restart_empty", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
